shift_ctrl: RTL

- Control stage directly upstream of the 4-bit rotate datapath. It drives that datapath's 2-bit pattern-select input and its 2-bit rotate-amount input.
- Converts raw board inputs into clean, registered control values: a bouncing push-button, a pattern-select switch pair, an auto-rotate enable and a direction switch.
- Steps the rotate amount once per debounced button press, or periodically in auto mode.

---
 rtl/shift_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/shift_ctrl.sv
// Control stage for the 4-bit rotate datapath: synchronises raw board inputs,
// debounces the step button and produces the registered pattern select and rotate amount.
module shift_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [1:0] sw_in,
  input  logic       auto_en,
  input  logic       dir,
  output logic [1:0] sw_out,
  output logic [1:0] k,
  output logic       step_pulse
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AP_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [AP_W-1:0] AP_LAST = AP_W'(AUTO_PERIOD - 1);

  logic            r_btn_m, r_btn_s;
  logic [1:0]      r_sw_m, r_sw_s;
  logic            r_auto_m, r_auto_s;
  logic            r_dir_m, r_dir_s;
  logic            r_btn_db, r_btn_db_d;
  logic [DB_W-1:0] r_db_cnt;
  logic [AP_W-1:0] r_auto_cnt;
  logic [1:0]      r_sw_out;
  logic [1:0]      r_k;
  logic            r_step;

  logic            w_btn_rise;
  logic            w_auto_tick;
  logic            w_step_req;
  logic            w_sw_change;

  // Modulo-4 step of the rotate amount; wrap falls out of the 2-bit width.
  function automatic logic [1:0] step_k(input logic [1:0] cur, input logic up);
    return up ? (cur + 2'd1) : (cur - 2'd1);
  endfunction

  always_comb begin
    w_btn_rise  = r_btn_db & ~r_btn_db_d;
    w_auto_tick = r_auto_s & (r_auto_cnt == AP_LAST);
    w_step_req  = w_btn_rise | w_auto_tick;
    w_sw_change = (r_sw_s != r_sw_out);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_m    <= 1'b0;
      r_btn_s    <= 1'b0;
      r_sw_m     <= 2'b00;
      r_sw_s     <= 2'b00;
      r_auto_m   <= 1'b0;
      r_auto_s   <= 1'b0;
      r_dir_m    <= 1'b0;
      r_dir_s    <= 1'b0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_db_cnt   <= '0;
      r_auto_cnt <= '0;
      r_sw_out   <= 2'b00;
      r_k        <= 2'b00;
      r_step     <= 1'b0;
    end else begin
      r_btn_m  <= btn;
      r_btn_s  <= r_btn_m;
      r_sw_m   <= sw_in;
      r_sw_s   <= r_sw_m;
      r_auto_m <= auto_en;
      r_auto_s <= r_auto_m;
      r_dir_m  <= dir;
      r_dir_s  <= r_dir_m;

      // Counter only runs while the synchronised button disagrees with the debounced level.
      if (r_btn_s != r_btn_db) begin
        if (r_db_cnt == DB_LAST) begin
          r_btn_db <= r_btn_s;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
      r_btn_db_d <= r_btn_db;

      if (!r_auto_s || (r_auto_cnt == AP_LAST))
        r_auto_cnt <= '0;
      else
        r_auto_cnt <= r_auto_cnt + AP_W'(1);

      // A pattern change swallows any step requested in the same cycle.
      if (w_sw_change) begin
        r_sw_out <= r_sw_s;
        r_k      <= 2'b00;
        r_step   <= 1'b0;
      end else if (w_step_req) begin
        r_k      <= step_k(r_k, r_dir_s);
        r_step   <= 1'b1;
      end else begin
        r_step   <= 1'b0;
      end
    end
  end

  assign sw_out     = r_sw_out;
  assign k          = r_k;
  assign step_pulse = r_step;

endmodule
